// File: rtl/vdp_sprite_hit_list_reader.sv
// Walks the sprite hit list RAM from address 0 and forwards each entry to the
// blitter as a valid/ready request until the terminator entry or the last address.
module vdp_sprite_hit_list_reader #(
    parameter int unsigned HIT_LIST_DEPTH = 256,
    parameter logic [7:0]  TERMINATOR_ID  = 8'hFF,
    localparam int unsigned ADDR_W  = 8,
    localparam int unsigned ID_W    = 8,
    localparam int unsigned Y_W     = 4,
    localparam int unsigned ENTRY_W = ID_W + Y_W + 1,
    localparam int unsigned CNT_W   = 9
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  hit_list_read_address,
    output logic               hit_list_read_en,
    input  logic [ENTRY_W-1:0] hit_list_read_data,
    output logic               blit_valid,
    input  logic               blit_ready,
    output logic [ID_W-1:0]    blit_sprite_id,
    output logic [Y_W-1:0]     blit_y_intersect,
    output logic               blit_width_select,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sprite_count
);

    localparam int unsigned PTR_W      = ADDR_W + 1;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FCNT_W     = 2;
    localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(HIT_LIST_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]                   read_addr_q, read_addr_d;
    logic                                read_en_q, read_en_d;
    logic                                rd_pending_q, rd_pending_d;
    logic [PTR_W-1:0]                    next_addr_q, next_addr_d;
    logic [FIFO_DEPTH-1:0][ENTRY_W-1:0]  fifo_q, fifo_d;
    logic [FCNT_W-1:0]                   fifo_cnt_q, fifo_cnt_d, cnt_mid;
    logic [ENTRY_W-1:0]                  blit_entry_q, blit_entry_d;
    logic                                blit_valid_q, blit_valid_d;
    logic [CNT_W-1:0]                    count_q, count_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;

    logic accept, term_hit, in_valid, slot_free, pop, push;
    logic issue, last_issue, finish;

    // Returned data is only meaningful the cycle after a read strobe that survived.
    assign accept    = blit_valid_q && blit_ready;
    assign term_hit  = rd_pending_q && (hit_list_read_data[ENTRY_W-1 -: ID_W] == TERMINATOR_ID);
    assign in_valid  = rd_pending_q && !term_hit;
    assign slot_free = !blit_valid_q || accept;
    assign pop       = slot_free && (fifo_cnt_q != '0);
    assign push      = in_valid && !(slot_free && (fifo_cnt_q == '0));

    // Credit check counts the read already on the bus; the output register is the third slot.
    assign issue = (state_q == FETCH) && !start && !term_hit &&
                   ((3'(fifo_cnt_d) + 3'(read_en_q)) < 3'd2);
    assign last_issue = start ? (LAST_ADDR == '0) : (issue && (next_addr_q == LAST_ADDR));
    assign finish = !start && ((state_q == DRAIN) || ((state_q == FETCH) && term_hit)) &&
                    !blit_valid_d && (fifo_cnt_d == '0) && !rd_pending_d;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start always wins and restarts the walk
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = last_issue ? DRAIN : FETCH;
            end
            FETCH: begin
                if (start)                        state_d = last_issue ? DRAIN : FETCH;
                else if (finish)                  state_d = IDLE;
                else if (term_hit || last_issue)  state_d = DRAIN;
            end
            DRAIN: begin
                if (start)       state_d = last_issue ? DRAIN : FETCH;
                else if (finish) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output-register next values: read port, busy and done
    always_comb begin
        read_en_d    = 1'b0;
        read_addr_d  = read_addr_q;
        next_addr_d  = next_addr_q;
        rd_pending_d = read_en_q && !term_hit && !start;
        busy_d       = (state_d != IDLE);
        done_d       = finish;
        if (start) begin
            read_en_d   = 1'b1;
            read_addr_d = '0;
            next_addr_d = PTR_W'(1);
        end else if (issue) begin
            read_en_d   = 1'b1;
            read_addr_d = ADDR_W'(next_addr_q);
            next_addr_d = next_addr_q + PTR_W'(1);
        end
    end

    // Output register fed from the FIFO head, or straight from the RAM when the FIFO is empty
    always_comb begin
        fifo_d       = fifo_q;
        cnt_mid      = fifo_cnt_q;
        fifo_cnt_d   = fifo_cnt_q;
        blit_entry_d = blit_entry_q;
        blit_valid_d = blit_valid_q;
        count_d      = count_q + CNT_W'(accept);
        if (start) begin
            fifo_cnt_d   = '0;
            blit_valid_d = 1'b0;
            count_d      = '0;
        end else begin
            if (slot_free) begin
                if (pop) begin
                    blit_entry_d = fifo_q[0];
                    blit_valid_d = 1'b1;
                end else if (in_valid) begin
                    blit_entry_d = hit_list_read_data;
                    blit_valid_d = 1'b1;
                end else begin
                    blit_valid_d = 1'b0;
                end
            end
            if (pop) begin
                fifo_d[0] = fifo_q[1];
                cnt_mid   = fifo_cnt_q - FCNT_W'(1);
            end
            if (push) begin
                fifo_d[cnt_mid[0]] = hit_list_read_data;
            end
            fifo_cnt_d = cnt_mid + FCNT_W'(push);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_addr_q  <= '0;
            read_en_q    <= 1'b0;
            rd_pending_q <= 1'b0;
            next_addr_q  <= '0;
            fifo_q       <= '0;
            fifo_cnt_q   <= '0;
            blit_entry_q <= '0;
            blit_valid_q <= 1'b0;
            count_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            read_addr_q  <= read_addr_d;
            read_en_q    <= read_en_d;
            rd_pending_q <= rd_pending_d;
            next_addr_q  <= next_addr_d;
            fifo_q       <= fifo_d;
            fifo_cnt_q   <= fifo_cnt_d;
            blit_entry_q <= blit_entry_d;
            blit_valid_q <= blit_valid_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign hit_list_read_address = read_addr_q;
    assign hit_list_read_en      = read_en_q;
    assign blit_valid            = blit_valid_q;
    assign blit_sprite_id        = blit_entry_q[ENTRY_W-1 -: ID_W];
    assign blit_y_intersect      = blit_entry_q[Y_W:1];
    assign blit_width_select     = blit_entry_q[0];
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign sprite_count          = count_q;

endmodule

// File: tb/tb_vdp_sprite_hit_list_reader.sv
// Bench for vdp_sprite_hit_list_reader: RAM model, scoreboard of expected
// blit requests and one task per scenario.
module tb_vdp_sprite_hit_list_reader;

    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  hit_list_read_address;
    logic        hit_list_read_en;
    logic [12:0] hit_list_read_data;
    logic        blit_valid;
    logic        blit_ready;
    logic [7:0]  blit_sprite_id;
    logic [3:0]  blit_y_intersect;
    logic        blit_width_select;
    logic        busy;
    logic        done;
    logic [8:0]  sprite_count;

    vdp_sprite_hit_list_reader #(.HIT_LIST_DEPTH(DEPTH), .TERMINATOR_ID(8'hFF)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .start                 (start),
        .hit_list_read_address (hit_list_read_address),
        .hit_list_read_en      (hit_list_read_en),
        .hit_list_read_data    (hit_list_read_data),
        .blit_valid            (blit_valid),
        .blit_ready            (blit_ready),
        .blit_sprite_id        (blit_sprite_id),
        .blit_y_intersect      (blit_y_intersect),
        .blit_width_select     (blit_width_select),
        .busy                  (busy),
        .done                  (done),
        .sprite_count          (sprite_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data valid the cycle after the strobe, noise otherwise
    logic [12:0] mem [DEPTH];
    always @(posedge clk) begin
        if (hit_list_read_en) hit_list_read_data <= mem[hit_list_read_address];
        else                  hit_list_read_data <= 13'($urandom);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [12:0] sb_q[$];
    int          acc_cyc[$];
    int          acc_cnt, done_cnt, done_cyc, first_valid_cyc, addr_err, next_exp, start_cyc;
    logic [12:0] last_acc, prev_out, exp_e;
    logic        prev_stall = 1'b0;
    logic        prev_start = 1'b0;
    logic [12:0] cur;
    assign cur = {blit_sprite_id, blit_y_intersect, blit_width_select};

    // Monitor: scoreboard pops on accept, stall stability, read address sequence
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (prev_stall && !prev_start) begin
                checks++;
                if (!blit_valid || cur !== prev_out) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b out=%h expected valid=1 out=%h", blit_valid, cur, prev_out);
                end
            end
            if (blit_valid && blit_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_request: got %h expected none", cur);
                end else begin
                    exp_e = sb_q.pop_front();
                    if (cur !== exp_e) begin
                        errors++;
                        $display("FAIL request_order: got %h expected %h", cur, exp_e);
                    end
                end
                acc_cnt++;
                acc_cyc.push_back(cyc);
                last_acc = cur;
            end
            if (blit_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_start) next_exp = 0;
            if (hit_list_read_en) begin
                if (32'(hit_list_read_address) != next_exp) addr_err++;
                next_exp = 32'(hit_list_read_address) + 1;
            end
            prev_stall = blit_valid && !blit_ready;
            prev_out   = cur;
            prev_start = start;
        end
    end

    task automatic clear_mon();
        acc_cnt = 0; done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
        addr_err = 0; next_exp = 0;
        acc_cyc.delete();
        sb_q.delete();
    endtask

    task automatic fill_mem();
        for (int i = 0; i < DEPTH; i++)
            mem[i] = {8'($urandom_range(0, 254)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))};
    endtask

    task automatic expect_list(input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(mem[i]);
    endtask

    task automatic start_list();
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(posedge clk); #1;
            if (done) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; blit_ready = 1'b0;
        fill_mem();
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({hit_list_read_en, blit_valid, busy, done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", {hit_list_read_en, blit_valid, busy, done});
        end
        checks++;
        if (hit_list_read_address !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 00", hit_list_read_address);
        end
        checks++;
        if (cur !== 13'h0) begin
            errors++;
            $display("FAIL reset_blit: got %h expected 0000", cur);
        end
        checks++;
        if (sprite_count !== 9'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", sprite_count);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        bit got;
        int a0, a1;
        fill_mem();
        mem[0] = {8'h03, 4'h5, 1'b1};
        mem[1] = {8'h07, 4'h0, 1'b0};
        mem[2] = {8'hFF, 4'($urandom), 1'($urandom)};
        clear_mon();
        expect_list(2);
        blit_ready = 1'b1;
        start_list();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b expected 1", busy);
        end
        wait_done(50, got);
        @(posedge clk); #1;
        a0 = (acc_cyc.size() > 0) ? acc_cyc[0] : -100;
        a1 = (acc_cyc.size() > 1) ? acc_cyc[1] : -100;
        checks++;
        if (!got) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
        // First request visible two edges after the edge that samples start
        checks++;
        if (first_valid_cyc - start_cyc != 3) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 3", first_valid_cyc - start_cyc);
        end
        checks++;
        if (acc_cnt != 2 || a1 - a0 != 1) begin
            errors++;
            $display("FAIL basic_accepts: got count=%0d gap=%0d expected count=2 gap=1", acc_cnt, a1 - a0);
        end
        checks++;
        if (done_cyc != a1 + 1) begin
            errors++;
            $display("FAIL basic_done_cycle: got %0d expected %0d", done_cyc, a1 + 1);
        end
        checks++;
        if (sprite_count !== 9'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_count: got count=%0d busy=%b expected count=2 busy=0", sprite_count, busy);
        end
        checks++;
        if (sb_q.size() != 0 || addr_err != 0) begin
            errors++;
            $display("FAIL basic_leftover: got pending=%0d addr_err=%0d expected 0 0", sb_q.size(), addr_err);
        end
    endtask

    task automatic test_term_first();
        bit got;
        fill_mem();
        mem[0] = {8'hFF, 4'h3, 1'b1};
        clear_mon();
        blit_ready = 1'b1;
        start_list();
        wait_done(50, got);
        @(posedge clk); #1;
        checks++;
        if (!got) begin errors++; $display("FAIL term_first_timeout: got no done expected done"); end
        checks++;
        if (first_valid_cyc != -1 || acc_cnt != 0) begin
            errors++;
            $display("FAIL term_first_valid: got first_valid=%0d accepts=%0d expected -1 0", first_valid_cyc, acc_cnt);
        end
        checks++;
        if (sprite_count !== 9'd0 || done_cyc - start_cyc != 3) begin
            errors++;
            $display("FAIL term_first_done: got count=%0d done_at=%0d expected 0 3", sprite_count, done_cyc - start_cyc);
        end
    endtask

    task automatic test_full_list();
        bit got;
        for (int i = 0; i < DEPTH; i++) mem[i] = {8'((i * 7) % 255), 4'(i), 1'(i)};
        clear_mon();
        expect_list(DEPTH);
        blit_ready = 1'b1;
        start_list();
        wait_done(700, got);
        @(posedge clk); #1;
        checks++;
        if (!got) begin errors++; $display("FAIL full_timeout: got no done expected done"); end
        checks++;
        if (acc_cnt != 256 || sprite_count !== 9'd256) begin
            errors++;
            $display("FAIL full_count: got accepts=%0d count=%0d expected 256 256", acc_cnt, sprite_count);
        end
        checks++;
        if (last_acc !== mem[255]) begin
            errors++;
            $display("FAIL full_last: got %h expected %h", last_acc, mem[255]);
        end
        checks++;
        if (addr_err != 0) begin
            errors++;
            $display("FAIL full_addr_seq: got %0d bad addresses expected 0", addr_err);
        end
        // One accept per cycle from start+3 through start+258, done right after
        checks++;
        if (done_cyc - start_cyc != 259) begin
            errors++;
            $display("FAIL full_throughput: got %0d expected 259", done_cyc - start_cyc);
        end
    endtask

    task automatic test_backpressure();
        bit got;
        fill_mem();
        mem[0] = {8'h21, 4'h1, 1'b0};
        mem[1] = {8'h42, 4'hA, 1'b1};
        mem[2] = {8'h63, 4'hF, 1'b1};
        mem[3] = {8'hFF, 4'h0, 1'b0};
        clear_mon();
        expect_list(3);
        blit_ready = 1'b0;
        start_list();
        repeat (6) @(posedge clk);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk); #1;
            blit_ready = 1'($urandom_range(0, 1));
            if (done) got = 1'b1;
        end
        blit_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (!got) begin errors++; $display("FAIL bp_timeout: got no done expected done"); end
        checks++;
        if (acc_cnt != 3 || sprite_count !== 9'd3 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: got accepts=%0d count=%0d pending=%0d expected 3 3 0", acc_cnt, sprite_count, sb_q.size());
        end
    endtask

    task automatic test_restart();
        bit got;
        fill_mem();
        for (int i = 0; i < 5; i++) mem[i] = {8'(8'h10 + i), 4'(i), 1'(i)};
        mem[5] = {8'hFF, 4'h0, 1'b1};
        clear_mon();
        expect_list(5);
        blit_ready = 1'b0;
        start_list();
        for (int i = 0; i < 20 && !blit_valid; i++) begin
            @(posedge clk); #1;
        end
        blit_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        blit_ready = 1'b0;
        checks++;
        if (acc_cnt != 2) begin
            errors++;
            $display("FAIL restart_first_accepts: got %0d expected 2", acc_cnt);
        end
        sb_q.delete();
        expect_list(5);
        start_list();
        checks++;
        if (hit_list_read_en !== 1'b1 || hit_list_read_address !== 8'h00 ||
            sprite_count !== 9'd0 || blit_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_reset_walk: got en=%b addr=%h count=%0d valid=%b expected 1 00 0 0",
                     hit_list_read_en, hit_list_read_address, sprite_count, blit_valid);
        end
        blit_ready = 1'b1;
        wait_done(60, got);
        @(posedge clk); #1;
        checks++;
        if (!got) begin errors++; $display("FAIL restart_timeout: got no done expected done"); end
        checks++;
        if (done_cnt != 1 || sprite_count !== 9'd5 || acc_cnt != 7 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL restart_result: got dones=%0d count=%0d accepts=%0d pending=%0d expected 1 5 7 0",
                     done_cnt, sprite_count, acc_cnt, sb_q.size());
        end
    endtask

    task automatic test_done_start_collision();
        bit got;
        fill_mem();
        mem[0] = {8'h12, 4'h3, 1'b0};
        mem[1] = {8'hFF, 4'h7, 1'b1};
        clear_mon();
        expect_list(1);
        blit_ready = 1'b1;
        start_list();
        repeat (2) begin @(posedge clk); #1; end
        // Last accept and terminator land in this cycle; start must suppress done
        start = 1'b1;
        expect_list(1);
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL collision_no_done: got done=%b busy=%b expected 0 1", done, busy);
        end
        wait_done(50, got);
        @(posedge clk); #1;
        checks++;
        if (!got) begin errors++; $display("FAIL collision_timeout: got no done expected done"); end
        checks++;
        if (done_cnt != 1 || sprite_count !== 9'd1 || acc_cnt != 2 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL collision_result: got dones=%0d count=%0d accepts=%0d pending=%0d expected 1 1 2 0",
                     done_cnt, sprite_count, acc_cnt, sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        fill_mem();
        mem[5] = {8'hFF, 4'h0, 1'b0};
        clear_mon();
        expect_list(5);
        blit_ready = 1'b1;
        start_list();
        repeat (3) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        sb_q.delete();
        checks++;
        if ({hit_list_read_en, blit_valid, busy, done} !== 4'b0 || hit_list_read_address !== 8'h00) begin
            errors++;
            $display("FAIL midreset_ctrl: got ctrl=%b addr=%h expected 0000 00",
                     {hit_list_read_en, blit_valid, busy, done}, hit_list_read_address);
        end
        checks++;
        if (cur !== 13'h0 || sprite_count !== 9'd0) begin
            errors++;
            $display("FAIL midreset_data: got blit=%h count=%0d expected 0000 0", cur, sprite_count);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done || busy || blit_valid || hit_list_read_en) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL midreset_idle: got activity after release expected idle");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_term_first();
        test_full_list();
        test_backpressure();
        test_restart();
        test_done_start_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
